frame_loader: RTL and testbench

Upstream stage feeding the pipeline sequencer. Takes the byte stream from the UART receiver and frames it with an optional sync byte. Writes IMG_W*IMG_H pixels, converted to fixed point, into the input image buffer, then pulses frame_loaded to start inference. The receive path is locked while the pipeline is busy, so a running frame is never overwritten.

---
 rtl/frame_loader_if.sv | 28 ++
 rtl/frame_loader.sv | 145 ++++++++++++++
 tb/tb_frame_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/frame_loader_if.sv
// rtl/frame_loader_if.sv - byte receive, image buffer write and status bundle of the frame loader
interface frame_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    logic                  i_rx_valid;
    logic [7:0]            i_rx_data;
    logic                  i_busy;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [DATA_WIDTH-1:0] o_wr_data;
    logic                  o_frame_loaded;
    logic                  o_frame_error;
    logic                  o_rx_drop;
    logic                  o_loading;

    modport master (
        input  i_rx_valid, i_rx_data, i_busy,
        output o_wr_en, o_wr_addr, o_wr_data,
        output o_frame_loaded, o_frame_error, o_rx_drop, o_loading
    );

    modport slave (
        output i_rx_valid, i_rx_data, i_busy,
        input  o_wr_en, o_wr_addr, o_wr_data,
        input  o_frame_loaded, o_frame_error, o_rx_drop, o_loading
    );
endinterface

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - frames the UART byte stream into the input image buffer
module frame_loader #(
    parameter int         IMG_W          = 28,
    parameter int         IMG_H          = 28,
    parameter int         ADDR_WIDTH     = 10,
    parameter int         DATA_WIDTH     = 16,
    parameter int         FRAC_BITS      = 7,
    parameter bit         USE_SYNC       = 1'b1,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input logic            clk,
    input logic            reset,
    frame_loader_if.master bus
);
    localparam int N  = IMG_W * IMG_H;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
    localparam logic [TW-1:0]         TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_HOLD_ARM, S_HOLD} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_count, w_count_nxt;
    logic [TW-1:0]         r_tcnt, w_tcnt_nxt;
    logic                  r_wr_en, w_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data;
    logic                  r_frame_loaded, w_frame_loaded;
    logic                  r_frame_error, w_frame_error;
    logic                  r_rx_drop, w_rx_drop;
    logic                  r_loading;
    logic [DATA_WIDTH-1:0] w_pixel;

    // Unsigned byte placed above the fractional bits; always non-negative.
    assign w_pixel = {{(DATA_WIDTH-8){1'b0}}, bus.i_rx_data} << FRAC_BITS;

    assign bus.o_wr_en        = r_wr_en;
    assign bus.o_wr_addr      = r_wr_addr;
    assign bus.o_wr_data      = r_wr_data;
    assign bus.o_frame_loaded = r_frame_loaded;
    assign bus.o_frame_error  = r_frame_error;
    assign bus.o_rx_drop      = r_rx_drop;
    assign bus.o_loading      = r_loading;

    // State, counters and every output are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_tcnt         <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_frame_loaded <= 1'b0;
            r_frame_error  <= 1'b0;
            r_rx_drop      <= 1'b0;
            r_loading      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_count        <= w_count_nxt;
            r_tcnt         <= w_tcnt_nxt;
            r_wr_en        <= w_wr_en;
            r_wr_addr      <= w_wr_addr;
            r_wr_data      <= w_wr_data;
            r_frame_loaded <= w_frame_loaded;
            r_frame_error  <= w_frame_error;
            r_rx_drop      <= w_rx_drop;
            r_loading      <= (w_state_nxt == S_LOAD);
        end
    end

    // Next state, pixel/timeout counters and the values the outputs take next cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_tcnt_nxt     = r_tcnt;
        w_wr_en        = 1'b0;
        w_wr_addr      = r_wr_addr;
        w_wr_data      = r_wr_data;
        w_frame_loaded = 1'b0;
        w_frame_error  = 1'b0;
        w_rx_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_rx_valid) begin
                    w_tcnt_nxt = '0;
                    if (USE_SYNC) begin
                        if (bus.i_rx_data == SYNC_BYTE) begin
                            w_state_nxt = S_LOAD;
                            w_count_nxt = '0;
                        end
                    end else begin
                        // Without a marker the first byte is already pixel 0.
                        w_wr_en     = 1'b1;
                        w_wr_addr   = '0;
                        w_wr_data   = w_pixel;
                        w_count_nxt = ADDR_WIDTH'(1);
                        w_state_nxt = (LAST_ADDR == '0) ? S_DONE : S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.i_rx_valid) begin
                    // Every byte here is a pixel, including one equal to the marker.
                    w_wr_en    = 1'b1;
                    w_wr_addr  = r_count;
                    w_wr_data  = w_pixel;
                    w_tcnt_nxt = '0;
                    if (r_count == LAST_ADDR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end else if (r_tcnt == TO_LAST) begin
                    w_frame_error = 1'b1;
                    w_state_nxt   = S_IDLE;
                    w_count_nxt   = '0;
                    w_tcnt_nxt    = '0;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            S_DONE: begin
                // One cycle after the last write strobe, so that write has landed.
                w_rx_drop      = bus.i_rx_valid;
                w_frame_loaded = 1'b1;
                w_state_nxt    = S_HOLD_ARM;
            end
            S_HOLD_ARM: begin
                w_rx_drop = bus.i_rx_valid;
                if (bus.i_busy) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_rx_drop = bus.i_rx_valid;
                if (!bus.i_busy) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
                w_tcnt_nxt  = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - directed self-checking bench for frame_loader
module tb_frame_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    frame_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus ();

    frame_loader #(
        .IMG_W(28), .IMG_H(28), .ADDR_WIDTH(10), .DATA_WIDTH(16), .FRAC_BITS(7),
        .USE_SYNC(1'b1), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    int n_wr, n_fl, n_fe, n_drop, addr_err, cur_run, max_run, fl_cyc, fe_cyc, last_cyc;
    int exp_next;
    logic [15:0] mem [0:1023];

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.o_wr_en) begin
            n_wr++;
            if (int'(bus.o_wr_addr) != exp_next) addr_err++;
            exp_next = int'(bus.o_wr_addr) + 1;
            mem[bus.o_wr_addr] = bus.o_wr_data;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
        if (bus.o_frame_loaded) begin n_fl++; fl_cyc = cyc; end
        if (bus.o_frame_error)  begin n_fe++; fe_cyc = cyc; end
        if (bus.o_rx_drop) n_drop++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        n_wr = 0; n_fl = 0; n_fe = 0; n_drop = 0; addr_err = 0;
        cur_run = 0; max_run = 0; fl_cyc = -1; fe_cyc = -1; exp_next = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        last_cyc = cyc;
        tick();
        bus.i_rx_valid = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic wait_fl(input int limit);
        for (int k = 0; k < limit && n_fl == 0; k++) tick();
    endtask

    initial begin
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_busy     = 1'b0;
        clr();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_wr_en",   32'(bus.o_wr_en), 32'd0);
        check("rst_loading", 32'(bus.o_loading), 32'd0);
        check("rst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.o_wr_data), 32'd0);
        check("rst_strobes", 32'({bus.o_frame_loaded, bus.o_frame_error, bus.o_rx_drop}), 32'd0);

        // Pre-sync bytes are ignored, then a full frame one byte every 4 cycles
        clr();
        send(8'h10, 4);
        send(8'h20, 4);
        check("presync_writes", 32'(n_wr), 32'd0);
        check("presync_drops",  32'(n_drop), 32'd0);
        check("presync_idle",   32'(bus.o_loading), 32'd0);
        send(8'hA5, 4);
        for (int i = 0; i < 784; i++) begin
            send(8'(i), 4);
            if (i == 400) check("loading_mid", 32'(bus.o_loading), 32'd1);
        end
        wait_fl(20);
        repeat (3) tick();
        check("f1_writes",  32'(n_wr), 32'd784);
        check("f1_addrseq", 32'(addr_err), 32'd0);
        check("f1_addr0",   32'(mem[0]), 32'h0000);
        check("f1_addr3",   32'(mem[3]), 32'h0180);
        check("f1_addr783", 32'(mem[783]), 32'h0780);
        check("f1_fl_count", 32'(n_fl), 32'd1);
        check("f1_fl_lat",  32'(fl_cyc - last_cyc), 32'd2);
        check("f1_drops",   32'(n_drop), 32'd0);

        // Locked while the sequencer is busy: five bytes dropped, no writes
        clr();
        bus.i_busy = 1'b1;
        for (int k = 0; k < 5; k++) send((k == 2) ? 8'hA5 : 8'(k + 1), 40);
        check("lock_drops",  32'(n_drop), 32'd5);
        check("lock_writes", 32'(n_wr), 32'd0);
        bus.i_busy = 1'b0;
        repeat (3) tick();
        check("lock_loading", 32'(bus.o_loading), 32'd0);

        // Timeout after 100 pixels, then a back-to-back frame with 0xA5 at pixel 10
        clr();
        send(8'hA5, 2);
        for (int i = 0; i < 100; i++) send(8'hFF, 1);
        for (int k = 0; k < 80 && n_fe == 0; k++) tick();
        repeat (3) tick();
        check("to_fe_count", 32'(n_fe), 32'd1);
        check("to_fe_lat",   32'((fe_cyc - last_cyc == 50) || (fe_cyc - last_cyc == 51)), 32'd1);
        check("to_no_fl",    32'(n_fl), 32'd0);
        check("to_writes",   32'(n_wr), 32'd100);
        check("to_idle",     32'(bus.o_loading), 32'd0);
        clr();
        send(8'hA5, 1);
        for (int i = 0; i < 784; i++) send((i == 10) ? 8'hA5 : 8'((i * 7 + 3) % 256), 1);
        wait_fl(20);
        repeat (3) tick();
        check("b2b_writes",  32'(n_wr), 32'd784);
        check("b2b_run",     32'(max_run), 32'd784);
        check("b2b_addrseq", 32'(addr_err), 32'd0);
        check("b2b_addr0",   32'(mem[0]), 32'h0180);
        check("b2b_addr10",  32'(mem[10]), 32'h5280);
        check("b2b_addr783", 32'(mem[783]), 32'h3600);
        check("b2b_fl",      32'(n_fl), 32'd1);
        bus.i_busy = 1'b1;
        repeat (3) tick();
        bus.i_busy = 1'b0;
        repeat (3) tick();

        // Reset in the middle of a frame
        clr();
        send(8'hA5, 1);
        for (int i = 0; i < 400; i++) send(8'(i), 1);
        reset = 1'b1;
        tick();
        check("mid_rst_wr_en",   32'(bus.o_wr_en), 32'd0);
        check("mid_rst_loading", 32'(bus.o_loading), 32'd0);
        check("mid_rst_addr",    32'(bus.o_wr_addr), 32'd0);
        check("mid_rst_writes",  32'(n_wr), 32'd400);
        reset = 1'b0;
        tick();
        tick();
        check("mid_rst_no_pulse", 32'(n_fl + n_fe), 32'd0);
        clr();
        send(8'hA5, 2);
        for (int i = 0; i < 784; i++) send(8'(i) ^ 8'h3C, 1);
        wait_fl(20);
        repeat (5) tick();
        check("post_rst_writes",  32'(n_wr), 32'd784);
        check("post_rst_addrseq", 32'(addr_err), 32'd0);
        check("post_rst_addr0",   32'(mem[0]), 32'h1E00);
        check("post_rst_fl",      32'(n_fl), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
